// File: rtl/ram_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and RAM-side signals seen by ram_port_arbiter.
// slave = arbiter view, master = requesters + RAM view.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) ();
    logic              IReq;
    logic [ADDR_W-1:0] IAddr;
    logic              IGrant;
    logic              IValid;
    logic [DATA_W-1:0] IRdata;

    logic              DReq;
    logic              DWrite;
    logic [ADDR_W-1:0] DAddr;
    logic [DATA_W-1:0] DWdata;
    logic              DGrant;
    logic              DValid;
    logic [DATA_W-1:0] DRdata;

    logic [ADDR_W-1:0] RamAddress;
    logic              RamMemWrite;
    logic [DATA_W-1:0] RamWriteData;
    logic [DATA_W-1:0] RamReadData;

    modport slave (
        input  IReq, IAddr, DReq, DWrite, DAddr, DWdata, RamReadData,
        output IGrant, IValid, IRdata, DGrant, DValid, DRdata,
        output RamAddress, RamMemWrite, RamWriteData
    );

    modport master (
        output IReq, IAddr, DReq, DWrite, DAddr, DWdata, RamReadData,
        input  IGrant, IValid, IRdata, DGrant, DValid, DRdata,
        input  RamAddress, RamMemWrite, RamWriteData
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares a single-port synchronous-read word RAM between fetch (I) and load/store (D).
// Define ARB_ROUND_ROBIN_EN for alternating priority instead of D priority with starvation guard.
//
// owner state | meaning
// OWN_NONE    | no RAM access issued last cycle, no response due
// OWN_I       | fetch issued last cycle, RamReadData goes to IRdata
// OWN_D       | load/store issued last cycle, DValid due (data only for loads)
module ram_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input logic           Clock,
    input logic           Reset,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e            owner_q, owner_d;
    logic              store_q, store_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;

    logic              grant_i, grant_d, i_wins_tie;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic              i_valid, d_valid;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;   // 1 when D won the most recent grant
    assign i_wins_tie = last_d_q;
`else
    logic [3:0] wait_cnt_q, wait_cnt_d;
    assign i_wins_tie = (wait_cnt_q == 4'(MAX_WAIT));
`endif

    always_comb begin
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        ram_addr    = hold_addr_q;
        ram_we      = 1'b0;
        ram_wdata   = '0;
        owner_d     = OWN_NONE;
        store_d     = 1'b0;
        hold_addr_d = hold_addr_q;

        if (!Reset) begin
            if (bus.IReq && bus.DReq) begin
                grant_i = i_wins_tie;
                grant_d = !i_wins_tie;
            end else begin
                grant_i = bus.IReq;
                grant_d = bus.DReq;
            end
        end

        if (grant_d) begin
            ram_addr    = bus.DAddr;
            ram_we      = bus.DWrite;
            ram_wdata   = bus.DWdata;
            owner_d     = OWN_D;
            store_d     = bus.DWrite;
            hold_addr_d = bus.DAddr;
        end else if (grant_i) begin
            ram_addr    = bus.IAddr;
            owner_d     = OWN_I;
            hold_addr_d = bus.IAddr;
        end

`ifdef ARB_ROUND_ROBIN_EN
        last_d_d = last_d_q;
        if (grant_d) begin
            last_d_d = 1'b1;
        end else if (grant_i) begin
            last_d_d = 1'b0;
        end
`else
        if (grant_i || !bus.IReq) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != 4'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            owner_q     <= OWN_NONE;
            store_q     <= 1'b0;
            hold_addr_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b0;
`else
            wait_cnt_q  <= 4'd0;
`endif
        end else begin
            owner_q     <= owner_d;
            store_q     <= store_d;
            hold_addr_q <= hold_addr_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q    <= last_d_d;
`else
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    // Responses are masked while Reset is high so an in-flight access never pulses valid.
    assign i_valid = (owner_q == OWN_I) && !Reset;
    assign d_valid = (owner_q == OWN_D) && !Reset;

    assign bus.IGrant       = grant_i;
    assign bus.DGrant       = grant_d;
    assign bus.RamAddress   = ram_addr;
    assign bus.RamMemWrite  = ram_we;
    assign bus.RamWriteData = ram_wdata;
    assign bus.IValid       = i_valid;
    assign bus.IRdata       = i_valid ? bus.RamReadData : '0;
    assign bus.DValid       = d_valid;
    assign bus.DRdata       = (d_valid && !store_q) ? bus.RamReadData : '0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised and directed bench for ram_port_arbiter (default D-priority build) with a
// behavioural RAM and a cycle-level reference model of the arbitration rules.
module tb_ram_port_arbiter;
    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // Behavioural single-port RAM, read-first, one-cycle read latency.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1] = '{default: '0};
    logic [DATA_W-1:0] ram_rd_q = '0;
    always @(posedge Clock) begin
        if (bus.RamMemWrite) mem[bus.RamAddress] <= bus.RamWriteData;
        ram_rd_q <= mem[bus.RamAddress];
    end
    assign bus.RamReadData = ram_rd_q;

    // Reference model state
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1] = '{default: '0};
    int                streak    = 0;
    logic [ADDR_W-1:0] held      = '0;
    logic              pend_i    = 1'b0;
    logic              pend_d    = 1'b0;
    logic [DATA_W-1:0] pend_data = '0;
    logic              last_ig   = 1'b0;
    logic              last_dg   = 1'b0;
    logic              obs_ig    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic              eig, edg, ewe, eiv, edv;
        logic [ADDR_W-1:0] eaddr;
        logic [DATA_W-1:0] ewd, eid, edd;
        @(negedge Clock);
        if (Reset) begin
            eig = 1'b0; edg = 1'b0;
        end else if (bus.IReq && bus.DReq) begin
            eig = (streak == MAX_WAIT); edg = !eig;
        end else begin
            eig = bus.IReq; edg = bus.DReq;
        end
        ewe   = edg && bus.DWrite;
        eaddr = edg ? bus.DAddr : (eig ? bus.IAddr : held);
        ewd   = edg ? bus.DWdata : '0;
        eiv   = pend_i && !Reset;
        edv   = pend_d && !Reset;
        eid   = eiv ? pend_data : '0;
        edd   = edv ? pend_data : '0;

        chk("IGrant", 32'(bus.IGrant), 32'(eig));
        chk("DGrant", 32'(bus.DGrant), 32'(edg));
        chk("both_grants", 32'(bus.IGrant & bus.DGrant), 32'd0);
        chk("RamMemWrite", 32'(bus.RamMemWrite), 32'(ewe));
        chk("RamAddress", 32'(bus.RamAddress), 32'(eaddr));
        if (!eig) chk("RamWriteData", bus.RamWriteData, ewd);
        chk("IValid", 32'(bus.IValid), 32'(eiv));
        chk("IRdata", bus.IRdata, eid);
        chk("DValid", 32'(bus.DValid), 32'(edv));
        chk("DRdata", bus.DRdata, edd);
        obs_ig = bus.IGrant;

        pend_i    = eig;
        pend_d    = edg;
        pend_data = eig ? shadow[bus.IAddr] : ((edg && !bus.DWrite) ? shadow[bus.DAddr] : '0);
        if (ewe) shadow[bus.DAddr] = bus.DWdata;
        if (Reset) held = '0;
        else if (eig || edg) held = eaddr;
        if (Reset || !bus.IReq || eig) streak = 0;
        else if (streak < MAX_WAIT) streak = streak + 1;
        last_ig = eig;
        last_dg = edg;
        @(posedge Clock);
        #1;
    endtask

    task automatic set_d(input logic req, input logic wr, input int addr, input logic [31:0] wd);
        bus.DReq   = req;
        bus.DWrite = wr;
        bus.DAddr  = ADDR_W'(addr);
        bus.DWdata = wd;
    endtask

    initial begin
        bus.IReq = 1'b0; bus.IAddr = '0;
        set_d(1'b0, 1'b0, 0, 32'h0);

        // Reset state
        repeat (2) step();
        Reset = 1'b0;
        step();

        // Store then load of address 5
        set_d(1'b1, 1'b1, 5, 32'h1234);
        step();
        set_d(1'b1, 1'b0, 5, 32'h0);
        step();
        set_d(1'b0, 1'b0, 0, 32'h0);
        step();

        // Preload 0..3 then back-to-back fetches
        for (int a = 0; a < 4; a++) begin
            set_d(1'b1, 1'b1, a, 32'h11 * (a + 1));
            step();
        end
        set_d(1'b0, 1'b0, 0, 32'h0);
        for (int a = 0; a < 4; a++) begin
            bus.IReq = 1'b1; bus.IAddr = ADDR_W'(a);
            step();
        end
        bus.IReq = 1'b0;
        step();
        step();

        // Continuous contention: D,D,D,D,I repeating
        bus.IReq = 1'b1; bus.IAddr = ADDR_W'(7);
        set_d(1'b1, 1'b0, 3, 32'h0);
        for (int k = 0; k < 15; k++) begin
            step();
            chk("contention_pattern", 32'(obs_ig), 32'((k % 5) == 4));
        end
        bus.IReq = 1'b0;
        set_d(1'b0, 1'b0, 0, 32'h0);
        step();

        // Store presented while Reset is high must not land
        Reset = 1'b1;
        set_d(1'b1, 1'b1, 5, 32'hDEAD);
        step();
        Reset = 1'b0;
        set_d(1'b1, 1'b0, 5, 32'h0);
        step();
        set_d(1'b0, 1'b0, 0, 32'h0);
        step();

        // Load granted, then Reset: response dropped
        set_d(1'b1, 1'b0, 1, 32'h0);
        step();
        Reset = 1'b1;
        set_d(1'b0, 1'b0, 0, 32'h0);
        step();
        Reset = 1'b0;
        step();

        // Randomised traffic with hold-until-granted requesters
        for (int n = 0; n < 1500; n++) begin
            if (!bus.IReq || last_ig) begin
                bus.IReq  = ($urandom_range(0, 3) != 0);
                bus.IAddr = ADDR_W'($urandom_range(0, 15));
            end
            if (!bus.DReq || last_dg) begin
                set_d(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 15)), $urandom);
            end
            Reset = ($urandom_range(0, 99) == 0);
            step();
        end
        Reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
